// File: rtl/usb_pkg.sv
// Shared PID codes, transaction FSM encoding and PID classification helpers.
package usb_pkg;

  localparam logic [3:0] PidOut   = 4'b0001;
  localparam logic [3:0] PidIn    = 4'b1001;
  localparam logic [3:0] PidSetup = 4'b1101;
  localparam logic [3:0] PidData0 = 4'b0011;
  localparam logic [3:0] PidData1 = 4'b1011;
  localparam logic [3:0] PidAck   = 4'b0010;
  localparam logic [3:0] PidNak   = 4'b1010;
  localparam logic [3:0] PidStall = 4'b1110;

  typedef enum logic [2:0] {
    StIdle,
    StRxData,
    StHsTx,
    StInTx,
    StInWaitHs
  } xact_state_e;

  function automatic logic is_token(input logic [3:0] pid);
    return (pid == PidOut) || (pid == PidIn) || (pid == PidSetup);
  endfunction

  function automatic logic is_data(input logic [3:0] pid);
    return (pid == PidData0) || (pid == PidData1);
  endfunction

endpackage

// File: rtl/usb_xact_ctrl_if.sv
// Bus between the transaction controller and its PHY/endpoint environment.
interface usb_xact_ctrl_if #(
  parameter int unsigned EP_NUM = 4
);

  logic              rx_pid_en;
  logic [3:0]        rx_pid;
  logic [3:0]        rx_endp;
  logic              crc5_err;
  logic              rx_eop_fire;
  logic              time_out;
  logic [EP_NUM-1:0] ep_in_rdy;
  logic [EP_NUM-1:0] ep_out_rdy;
  logic [EP_NUM-1:0] ep_stall;
  logic [3:0]        tx_pid;
  logic              tx_valid;
  logic              tx_ready;
  logic              in_start;
  logic [3:0]        in_pid;
  logic              in_done;
  logic [3:0]        xact_endp;
  logic              out_commit;
  logic              out_discard;
  logic              in_ack;

  // Controller side
  modport master (
    input  rx_pid_en, rx_pid, rx_endp, crc5_err, rx_eop_fire, time_out,
    input  ep_in_rdy, ep_out_rdy, ep_stall, tx_ready, in_done,
    output tx_pid, tx_valid, in_start, in_pid, xact_endp, out_commit, out_discard, in_ack
  );

  // PHY / endpoint side
  modport slave (
    output rx_pid_en, rx_pid, rx_endp, crc5_err, rx_eop_fire, time_out,
    output ep_in_rdy, ep_out_rdy, ep_stall, tx_ready, in_done,
    input  tx_pid, tx_valid, in_start, in_pid, xact_endp, out_commit, out_discard, in_ack
  );

endinterface

// File: rtl/usb_toggle_bank.sv
// One data-toggle bit per endpoint with set/flip/clear on a selected endpoint.
// Indices at or beyond EP_NUM read as 0 and ignore writes.
module usb_toggle_bank #(
  parameter int unsigned EP_NUM = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] idx_i,
  input  logic       set_i,
  input  logic       flip_i,
  input  logic       clr_i,
  output logic       rd_o
);

  logic [EP_NUM-1:0] bits_q, bits_d;

  // Next-state and read mux; loop compare avoids an oversized index.
  always_comb begin
    bits_d = bits_q;
    rd_o   = 1'b0;
    for (int i = 0; i < int'(EP_NUM); i++) begin
      if (idx_i == 4'(i)) begin
        rd_o = bits_q[i];
        if (clr_i) begin
          bits_d[i] = 1'b0;
        end else if (set_i) begin
          bits_d[i] = 1'b1;
        end else if (flip_i) begin
          bits_d[i] = ~bits_q[i];
        end
      end
    end
  end

  // Toggle storage
  always_ff @(posedge clk) begin
    if (rst) begin
      bits_q <= '0;
    end else begin
      bits_q <= bits_d;
    end
  end

endmodule

// File: rtl/usb_xact_ctrl.sv
// USB device transaction controller: decodes tokens, tracks data toggles,
// issues handshakes and steers endpoint commit/discard/IN streaming.
module usb_xact_ctrl
  import usb_pkg::*;
#(
  parameter int unsigned EP_NUM = 4
) (
  input logic            clk,
  input logic            rst,
  usb_xact_ctrl_if.master bus
);

  xact_state_e state_q, state_d;
  logic [3:0]  ep_q, ep_d;
  logic        setup_q, setup_d;
  logic [3:0]  data_pid_q, data_pid_d;
  logic [3:0]  tx_pid_q, tx_pid_d;
  logic        tx_valid_q, tx_valid_d;
  logic        in_start_q, in_start_d;
  logic [3:0]  in_pid_q, in_pid_d;
  logic        out_commit_q, out_commit_d;
  logic        out_discard_q, out_discard_d;
  logic        in_ack_q, in_ack_d;

  logic [3:0]  sel_idx;
  logic        ep_ok, sel_stall, sel_in_rdy, sel_out_rdy;
  logic        in_tog, out_tog;
  logic        in_set, in_flip, out_set, out_flip;
  logic        tok_ok;

  // In IDLE the decision is about the incoming token's endpoint, otherwise the latched one.
  always_comb begin
    sel_idx     = (state_q == StIdle) ? bus.rx_endp : ep_q;
    ep_ok       = 32'(sel_idx) < EP_NUM;
    sel_stall   = 1'b0;
    sel_in_rdy  = 1'b0;
    sel_out_rdy = 1'b0;
    for (int i = 0; i < int'(EP_NUM); i++) begin
      if (sel_idx == 4'(i)) begin
        sel_stall   = bus.ep_stall[i];
        sel_in_rdy  = bus.ep_in_rdy[i];
        sel_out_rdy = bus.ep_out_rdy[i];
      end
    end
  end

  usb_toggle_bank #(.EP_NUM(EP_NUM)) u_in_tog (
    .clk   (clk),
    .rst   (rst),
    .idx_i (sel_idx),
    .set_i (in_set),
    .flip_i(in_flip),
    .clr_i (1'b0),
    .rd_o  (in_tog)
  );

  usb_toggle_bank #(.EP_NUM(EP_NUM)) u_out_tog (
    .clk   (clk),
    .rst   (rst),
    .idx_i (sel_idx),
    .set_i (out_set),
    .flip_i(out_flip),
    .clr_i (1'b0),
    .rd_o  (out_tog)
  );

  // Transaction FSM next state, registered outputs and toggle updates.
  always_comb begin
    state_d       = state_q;
    ep_d          = ep_q;
    setup_d       = setup_q;
    data_pid_d    = data_pid_q;
    tx_pid_d      = tx_pid_q;
    tx_valid_d    = tx_valid_q;
    in_pid_d      = in_pid_q;
    in_start_d    = 1'b0;
    out_commit_d  = 1'b0;
    out_discard_d = 1'b0;
    in_ack_d      = 1'b0;
    in_set        = 1'b0;
    in_flip       = 1'b0;
    out_set       = 1'b0;
    out_flip      = 1'b0;
    tok_ok        = bus.rx_pid_en && is_token(bus.rx_pid);

    unique case (state_q)
      StIdle: begin
        if (tok_ok && !bus.crc5_err) begin
          ep_d = bus.rx_endp;
          if (bus.rx_pid == PidIn) begin
            setup_d = 1'b0;
            if (!ep_ok || sel_stall) begin
              tx_pid_d   = PidStall;
              tx_valid_d = 1'b1;
              state_d    = StHsTx;
            end else if (!sel_in_rdy) begin
              tx_pid_d   = PidNak;
              tx_valid_d = 1'b1;
              state_d    = StHsTx;
            end else begin
              in_start_d = 1'b1;
              in_pid_d   = in_tog ? PidData1 : PidData0;
              state_d    = StInTx;
            end
          end else begin
            setup_d    = (bus.rx_pid == PidSetup);
            // Invalid marker: an eop without a data PID can never match the toggle.
            data_pid_d = 4'b0000;
            state_d    = StRxData;
          end
        end
      end

      StRxData: begin
        if (tok_ok) begin
          state_d = StIdle;
        end else if (bus.rx_eop_fire) begin
          state_d    = StHsTx;
          tx_valid_d = 1'b1;
          tx_pid_d   = PidAck;
          if (setup_q) begin
            out_commit_d = 1'b1;
            in_set       = 1'b1;
            out_set      = 1'b1;
          end else if (!ep_ok || sel_stall) begin
            tx_pid_d      = PidStall;
            out_discard_d = 1'b1;
          end else if (!sel_out_rdy) begin
            tx_pid_d      = PidNak;
            out_discard_d = 1'b1;
          end else if (data_pid_q != (out_tog ? PidData1 : PidData0)) begin
            out_discard_d = 1'b1;
          end else begin
            out_commit_d = 1'b1;
            out_flip     = 1'b1;
          end
        end else if (bus.time_out) begin
          state_d = StIdle;
        end else if (bus.rx_pid_en && is_data(bus.rx_pid)) begin
          data_pid_d = bus.rx_pid;
        end
      end

      StHsTx: begin
        if (bus.tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = StIdle;
        end
      end

      StInTx: begin
        if (bus.in_done) begin
          state_d = StInWaitHs;
        end
      end

      StInWaitHs: begin
        // ACK is checked first so it wins over a coincident timeout.
        if (bus.rx_pid_en && (bus.rx_pid == PidAck)) begin
          in_flip  = 1'b1;
          in_ack_d = 1'b1;
          state_d  = StIdle;
        end else if (bus.rx_pid_en || bus.time_out) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      ep_q          <= 4'd0;
      setup_q       <= 1'b0;
      data_pid_q    <= PidData0;
      tx_pid_q      <= 4'b0000;
      tx_valid_q    <= 1'b0;
      in_start_q    <= 1'b0;
      in_pid_q      <= PidData0;
      out_commit_q  <= 1'b0;
      out_discard_q <= 1'b0;
      in_ack_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      ep_q          <= ep_d;
      setup_q       <= setup_d;
      data_pid_q    <= data_pid_d;
      tx_pid_q      <= tx_pid_d;
      tx_valid_q    <= tx_valid_d;
      in_start_q    <= in_start_d;
      in_pid_q      <= in_pid_d;
      out_commit_q  <= out_commit_d;
      out_discard_q <= out_discard_d;
      in_ack_q      <= in_ack_d;
    end
  end

  assign bus.tx_pid      = tx_pid_q;
  assign bus.tx_valid    = tx_valid_q;
  assign bus.in_start    = in_start_q;
  assign bus.in_pid      = in_pid_q;
  assign bus.xact_endp   = ep_q;
  assign bus.out_commit  = out_commit_q;
  assign bus.out_discard = out_discard_q;
  assign bus.in_ack      = in_ack_q;

endmodule

// File: tb/tb_usb_xact_ctrl.sv
// Directed bench for usb_xact_ctrl with hand-computed expectations.
module tb_usb_xact_ctrl;
  import usb_pkg::*;

  localparam int unsigned EpNum = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  usb_xact_ctrl_if #(.EP_NUM(EpNum)) bus ();

  usb_xact_ctrl #(.EP_NUM(EpNum)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pid(input logic [3:0] pid, input logic [3:0] endp);
    bus.rx_pid_en = 1'b1;
    bus.rx_pid    = pid;
    bus.rx_endp   = endp;
    tick();
    bus.rx_pid_en = 1'b0;
  endtask

  task automatic eop();
    bus.rx_eop_fire = 1'b1;
    tick();
    bus.rx_eop_fire = 1'b0;
  endtask

  // Hold tx_ready low for 'hold' cycles, then accept; tx_valid must drop right after.
  task automatic hs_accept(input string tag, input logic [3:0] pid, input int hold);
    for (int i = 0; i < hold; i++) begin
      check({tag, " valid"}, 32'(bus.tx_valid), 32'd1);
      check({tag, " pid"}, 32'(bus.tx_pid), 32'(pid));
      tick();
    end
    check({tag, " valid last"}, 32'(bus.tx_valid), 32'd1);
    check({tag, " pid last"}, 32'(bus.tx_pid), 32'(pid));
    bus.tx_ready = 1'b1;
    tick();
    bus.tx_ready = 1'b0;
    check({tag, " valid drop"}, 32'(bus.tx_valid), 32'd0);
  endtask

  task automatic out_xact(input string tag, input logic [3:0] tok, input logic [3:0] endp,
                          input logic [3:0] dpid, input logic [3:0] hs, input logic commit,
                          input logic discard);
    send_pid(tok, endp);
    check({tag, " endp"}, 32'(bus.xact_endp), 32'(endp));
    send_pid(dpid, 4'd0);
    eop();
    check({tag, " commit"}, 32'(bus.out_commit), 32'(commit));
    check({tag, " discard"}, 32'(bus.out_discard), 32'(discard));
    hs_accept(tag, hs, 0);
    check({tag, " commit end"}, 32'(bus.out_commit), 32'd0);
    check({tag, " discard end"}, 32'(bus.out_discard), 32'd0);
  endtask

  task automatic in_xact(input string tag, input logic [3:0] endp, input logic [3:0] dpid,
                         input logic ack);
    send_pid(PidIn, endp);
    check({tag, " start"}, 32'(bus.in_start), 32'd1);
    check({tag, " pid"}, 32'(bus.in_pid), 32'(dpid));
    check({tag, " no hs"}, 32'(bus.tx_valid), 32'd0);
    tick();
    check({tag, " start end"}, 32'(bus.in_start), 32'd0);
    check({tag, " pid hold"}, 32'(bus.in_pid), 32'(dpid));
    bus.in_done = 1'b1;
    tick();
    bus.in_done = 1'b0;
    bus.time_out = 1'b1;
    if (ack) begin
      bus.rx_pid_en = 1'b1;
      bus.rx_pid    = PidAck;
    end
    tick();
    bus.time_out  = 1'b0;
    bus.rx_pid_en = 1'b0;
    check({tag, " ack"}, 32'(bus.in_ack), 32'(ack));
    tick();
    check({tag, " ack end"}, 32'(bus.in_ack), 32'd0);
  endtask

  initial begin
    rst             = 1'b1;
    bus.rx_pid_en   = 1'b0;
    bus.rx_pid      = 4'd0;
    bus.rx_endp     = 4'd0;
    bus.crc5_err    = 1'b0;
    bus.rx_eop_fire = 1'b0;
    bus.time_out    = 1'b0;
    bus.ep_in_rdy   = 4'b1011;
    bus.ep_out_rdy  = 4'b1111;
    bus.ep_stall    = 4'b0000;
    bus.tx_ready    = 1'b0;
    bus.in_done     = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check("rst tx_valid", 32'(bus.tx_valid), 32'd0);
    check("rst tx_pid", 32'(bus.tx_pid), 32'd0);
    check("rst in_pid", 32'(bus.in_pid), 32'(PidData0));
    check("rst endp", 32'(bus.xact_endp), 32'd0);
    check("rst pulses", 32'({bus.in_start, bus.out_commit, bus.out_discard, bus.in_ack}),
          32'd0);

    // OUT toggle sequencing on ep1
    out_xact("out1 d0", PidOut, 4'd1, PidData0, PidAck, 1'b1, 1'b0);
    out_xact("out1 d0 rpt", PidOut, 4'd1, PidData0, PidAck, 1'b0, 1'b1);
    out_xact("out1 d1", PidOut, 4'd1, PidData1, PidAck, 1'b1, 1'b0);

    // No buffer space on ep0
    bus.ep_out_rdy = 4'b1110;
    out_xact("out0 nak", PidOut, 4'd0, PidData0, PidNak, 1'b0, 1'b1);
    bus.ep_out_rdy = 4'b1111;

    // IN with no data: NAK held through 5 stalled cycles
    send_pid(PidIn, 4'd2);
    check("in2 no start", 32'(bus.in_start), 32'd0);
    hs_accept("in2 nak", PidNak, 5);

    // IN toggle: ACK+timeout flips, timeout alone does not
    in_xact("in0 a", 4'd0, PidData0, 1'b1);
    in_xact("in0 b", 4'd0, PidData1, 1'b0);
    in_xact("in0 c", 4'd0, PidData1, 1'b1);

    // Token with CRC error is ignored
    bus.crc5_err = 1'b1;
    send_pid(PidIn, 4'd1);
    bus.crc5_err = 1'b0;
    check("crc no start", 32'(bus.in_start), 32'd0);
    check("crc no hs", 32'(bus.tx_valid), 32'd0);
    check("crc endp", 32'(bus.xact_endp), 32'd0);

    // Timeout in RX_DATA abandons silently; ep1 OUT toggle still 0
    send_pid(PidOut, 4'd1);
    bus.time_out = 1'b1;
    tick();
    bus.time_out = 1'b0;
    tick();
    check("abandon hs", 32'(bus.tx_valid), 32'd0);
    check("abandon pulses", 32'({bus.out_commit, bus.out_discard}), 32'd0);
    out_xact("out1 after", PidOut, 4'd1, PidData0, PidAck, 1'b1, 1'b0);

    // SETUP ignores stall and sets both toggles of ep3
    bus.ep_stall = 4'b1000;
    out_xact("setup3", PidSetup, 4'd3, PidData0, PidAck, 1'b1, 1'b0);
    out_xact("out3 stall", PidOut, 4'd3, PidData1, PidStall, 1'b0, 1'b1);
    send_pid(PidIn, 4'd3);
    hs_accept("in3 stall", PidStall, 0);
    bus.ep_stall = 4'b0000;
    in_xact("in3", 4'd3, PidData1, 1'b0);
    out_xact("out3", PidOut, 4'd3, PidData1, PidAck, 1'b1, 1'b0);

    // Out-of-range endpoint stalls; reset during the handshake
    send_pid(PidOut, 4'd5);
    check("ep5 endp", 32'(bus.xact_endp), 32'd5);
    send_pid(PidData0, 4'd0);
    eop();
    check("ep5 valid", 32'(bus.tx_valid), 32'd1);
    check("ep5 pid", 32'(bus.tx_pid), 32'(PidStall));
    check("ep5 discard", 32'(bus.out_discard), 32'd1);
    rst = 1'b1;
    tick();
    check("mid rst valid", 32'(bus.tx_valid), 32'd0);
    check("mid rst pulses", 32'({bus.in_start, bus.out_commit, bus.out_discard, bus.in_ack}),
          32'd0);
    check("mid rst endp", 32'(bus.xact_endp), 32'd0);
    check("mid rst in_pid", 32'(bus.in_pid), 32'(PidData0));
    rst = 1'b0;
    tick();
    check("post rst valid", 32'(bus.tx_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
